// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between an instruction-fetch port and a data load/store port.
// One transaction at a time; data has priority, with a streak limit so fetch cannot starve.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rddata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wrdata,
  input  logic        d_wren,
  output logic        d_ack,
  output logic [31:0] d_rddata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic        bus_wren,
  input  logic [31:0] bus_rddata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic [3:0] CntInit   = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] StreakMax = 4'(MAX_D_STREAK);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        owner_q, owner_d;
  logic        store_q, store_d;
  logic        bus_wren_q, bus_wren_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wrdata_q, bus_wrdata_d;
  logic [31:0] if_rddata_q, if_rddata_d;
  logic [31:0] d_rddata_q, d_rddata_d;

  logic grant;
  logic pick_data;
  logic last_beat;

  always_comb begin
    grant     = (state_q == StIdle) && (if_req || d_req);
    // Data wins a tie unless it has already used up its streak while fetch waited.
    pick_data = d_req && !(if_req && (streak_q == StreakMax));
    last_beat = (state_q == StAccess) && (cnt_q == 4'd0);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (grant) state_d = StAccess;
      StAccess: if (cnt_q == 4'd0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != StIdle);
    owner  = owner_q;
    if_ack = (state_q == StDone) && !owner_q;
    d_ack  = (state_q == StDone) && owner_q;
  end

  // Datapath next state
  always_comb begin
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    owner_d      = owner_q;
    store_d      = store_q;
    bus_wren_d   = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wrdata_d = bus_wrdata_q;
    if_rddata_d  = if_rddata_q;
    d_rddata_d   = d_rddata_q;

    if (grant) begin
      owner_d = pick_data;
      cnt_d   = CntInit;
      if (pick_data) begin
        bus_addr_d   = d_addr;
        bus_wrdata_d = d_wrdata;
        bus_wren_d   = d_wren;
        store_d      = d_wren;
      end else begin
        bus_addr_d   = if_addr;
        bus_wrdata_d = 32'h0;
        store_d      = 1'b0;
      end
    end else if ((state_q == StAccess) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (state_q == StIdle) begin
      if (grant && !pick_data) begin
        streak_d = 4'd0;
      end else if (grant && if_req) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 4'd1;
      end else if (!if_req) begin
        streak_d = 4'd0;
      end
    end

    // Store read-back is meaningless, so d_rddata keeps the last load value.
    if (last_beat) begin
      if (!owner_q) begin
        if_rddata_d = bus_rddata;
      end else if (!store_q) begin
        d_rddata_d = bus_rddata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= 4'd0;
      streak_q     <= 4'd0;
      owner_q      <= 1'b0;
      store_q      <= 1'b0;
      bus_wren_q   <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wrdata_q <= 32'h0;
      if_rddata_q  <= 32'h0;
      d_rddata_q   <= 32'h0;
    end else begin
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      bus_wren_q   <= bus_wren_d;
      bus_addr_q   <= bus_addr_d;
      bus_wrdata_q <= bus_wrdata_d;
      if_rddata_q  <= if_rddata_d;
      d_rddata_q   <= d_rddata_d;
    end
  end

  assign bus_addr   = bus_addr_q;
  assign bus_wrdata = bus_wrdata_q;
  assign bus_wren   = bus_wren_q;
  assign if_rddata  = if_rddata_q;
  assign d_rddata   = d_rddata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-schedule model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int unsigned WAIT = 3;
  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_wren;
  logic [31:0] if_addr, d_addr, d_wrdata;
  logic        if_ack, d_ack, bus_wren, busy, owner;
  logic [31:0] if_rddata, d_rddata, bus_addr, bus_wrdata, bus_rddata;
  logic        mem_ovr_en;
  logic [31:0] mem_ovr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus_rddata = mem_ovr_en ? mem_ovr : mem_f(bus_addr);

  mem_bus_arbiter #(
    .WAIT_CYCLES (WAIT),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rddata (if_rddata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wrdata  (d_wrdata),
    .d_wren    (d_wren),
    .d_ack     (d_ack),
    .d_rddata  (d_rddata),
    .bus_addr  (bus_addr),
    .bus_wrdata(bus_wrdata),
    .bus_wren  (bus_wren),
    .bus_rddata(bus_rddata),
    .busy      (busy),
    .owner     (owner)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, if_ack, d_ack, bus_wren, owner} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b, want 00000", {busy, if_ack, d_ack, bus_wren, owner});
    end
    vectors++;
    if ({bus_addr, bus_wrdata, if_rddata, d_rddata} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, want 0", {bus_addr, bus_wrdata, if_rddata, d_rddata});
    end
    rst = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_wren = 1'b1; d_addr = 32'h1001_0008; d_wrdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if ({bus_wren, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_pre_access: got %b, want 11", {bus_wren, busy});
    end
    d_req = 1'b0; d_wren = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus_wren, busy, if_ack, d_ack} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_async: got %b, want 0000", {bus_wren, busy, if_ack, d_ack});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({busy, if_ack, d_ack, bus_wren, owner, bus_addr, bus_wrdata, if_rddata, d_rddata}
          !== 133'h0) begin
        miscompares++;
        $display("FAIL reset_idle: cycle %0d outputs nonzero, busy=%b acks=%b%b addr=%h",
                 k, busy, if_ack, d_ack, bus_addr);
      end
    end
  endtask

  task automatic test_single_fetch();
    mem_ovr_en = 1'b1; mem_ovr = 32'h0050_0093;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0004;
    for (int k = 1; k <= int'(WAIT) + 1; k++) begin
      @(negedge clk);
      vectors++;
      if (bus_addr !== 32'h0040_0004 || bus_wren !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_bus: k=%0d got addr=%h wren=%b, want 00400004/0", k, bus_addr,
                 bus_wren);
      end
      vectors++;
      if (if_ack !== (k == int'(WAIT) + 1)) begin
        miscompares++;
        $display("FAIL fetch_ack: k=%0d got %b, want %b", k, if_ack, k == int'(WAIT) + 1);
      end
      if (k == int'(WAIT) + 1) begin
        vectors++;
        if (if_rddata !== 32'h0050_0093) begin
          miscompares++;
          $display("FAIL fetch_data: got %h, want 00500093", if_rddata);
        end
        if_req = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({if_ack, busy, bus_wren} !== 3'b0 || if_rddata !== 32'h0050_0093) begin
        miscompares++;
        $display("FAIL fetch_hold: got ack=%b busy=%b wren=%b data=%h, want 0/0/0/00500093",
                 if_ack, busy, bus_wren, if_rddata);
      end
    end
  endtask

  task automatic test_store();
    int wr_cnt = 0;
    mem_ovr_en = 1'b1; mem_ovr = 32'h1357_2468;
    @(negedge clk);
    d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h1001_0000;
    repeat (WAIT + 1) @(negedge clk);
    vectors++;
    if (d_ack !== 1'b1 || d_rddata !== 32'h1357_2468) begin
      miscompares++;
      $display("FAIL store_preload: got ack=%b data=%h, want 1/13572468", d_ack, d_rddata);
    end
    d_req = 1'b0;
    mem_ovr = 32'hFFFF_0000;
    @(negedge clk);
    d_req = 1'b1; d_wren = 1'b1; d_addr = 32'h1001_0008; d_wrdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= int'(WAIT) + 1; k++) begin
      @(negedge clk);
      if (bus_wren === 1'b1) wr_cnt++;
      vectors++;
      if (bus_wren !== (k == 1)) begin
        miscompares++;
        $display("FAIL store_wren: k=%0d got %b, want %b", k, bus_wren, k == 1);
      end
      vectors++;
      if (bus_addr !== 32'h1001_0008 || bus_wrdata !== 32'hDEAD_BEEF) begin
        miscompares++;
        $display("FAIL store_bus: k=%0d got %h/%h, want 10010008/deadbeef", k, bus_addr,
                 bus_wrdata);
      end
      vectors++;
      if (d_ack !== (k == int'(WAIT) + 1)) begin
        miscompares++;
        $display("FAIL store_ack: k=%0d got %b, want %b", k, d_ack, k == int'(WAIT) + 1);
      end
    end
    vectors++;
    if (d_rddata !== 32'h1357_2468) begin
      miscompares++;
      $display("FAIL store_rddata: got %h, want 13572468", d_rddata);
    end
    vectors++;
    if (wr_cnt != 1) begin
      miscompares++;
      $display("FAIL store_pulses: got %0d, want 1", wr_cnt);
    end
    d_req = 1'b0; d_wren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [31:0] fa = 32'h0040_0100;
    logic [31:0] da = 32'h1001_0040;
    mem_ovr_en = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = fa;
    d_req = 1'b1; d_wren = 1'b0; d_addr = da;
    for (int k = 1; k <= 2 * int'(WAIT) + 3; k++) begin
      @(negedge clk);
      vectors++;
      if (if_ack && d_ack) begin
        miscompares++;
        $display("FAIL simul_overlap: k=%0d both acks high, want at most one", k);
      end
      if (k <= int'(WAIT) + 1) begin
        vectors++;
        if ({busy, owner, d_ack, if_ack} !== {2'b11, k == int'(WAIT) + 1, 1'b0}) begin
          miscompares++;
          $display("FAIL simul_data: k=%0d got busy/owner/dack/iack=%b%b%b%b", k, busy, owner,
                   d_ack, if_ack);
        end
        if (k == int'(WAIT) + 1) begin
          vectors++;
          if (d_rddata !== mem_f(da)) begin
            miscompares++;
            $display("FAIL simul_ddata: got %h, want %h", d_rddata, mem_f(da));
          end
          d_req = 1'b0;
        end
      end else if (k == int'(WAIT) + 2) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL simul_idle_gap: got busy=%b, want 0", busy);
        end
      end else begin
        vectors++;
        if ({busy, owner} !== 2'b10 || bus_addr !== fa ||
            if_ack !== (k == 2 * int'(WAIT) + 3)) begin
          miscompares++;
          $display("FAIL simul_fetch: k=%0d got busy=%b owner=%b addr=%h ack=%b", k, busy,
                   owner, bus_addr, if_ack);
        end
      end
    end
    vectors++;
    if (if_rddata !== mem_f(fa)) begin
      miscompares++;
      $display("FAIL simul_idata: got %h, want %h", if_rddata, mem_f(fa));
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit seq[$];
    logic [9:0] exp_seq = 10'b1111011110;
    bit d_rearm = 1'b0;
    bit i_rearm = 1'b0;
    mem_ovr_en = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0200;
    d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h1001_0080;
    for (int c = 0; c < 12 * (int'(WAIT) + 2) + 4 && seq.size() < 10; c++) begin
      @(negedge clk);
      if (d_rearm) begin d_req = 1'b1; d_rearm = 1'b0; end
      if (i_rearm) begin if_req = 1'b1; i_rearm = 1'b0; end
      if (d_ack === 1'b1) begin seq.push_back(1'b1); d_req = 1'b0; d_rearm = 1'b1; end
      if (if_ack === 1'b1) begin seq.push_back(1'b0); if_req = 1'b0; i_rearm = 1'b1; end
    end
    if_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (seq.size() != 10) begin
      miscompares++;
      $display("FAIL starve_count: got %0d grants, want 10 (timeout)", seq.size());
    end
    for (int i = 0; i < seq.size() && i < 10; i++) begin
      vectors++;
      if (seq[i] !== exp_seq[9-i]) begin
        miscompares++;
        $display("FAIL starve_order: grant %0d got owner %b, want %b", i, seq[i], exp_seq[9-i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_isolation();
    mem_ovr_en = 1'b1; mem_ovr = 32'h1111_1111;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0300;
    repeat (WAIT + 1) @(negedge clk);
    vectors++;
    if (if_ack !== 1'b1 || if_rddata !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL iso_fetch: got ack=%b data=%h, want 1/11111111", if_ack, if_rddata);
    end
    if_req = 1'b0;
    @(negedge clk);
    mem_ovr = 32'h2222_2222;
    d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h1001_0100;
    repeat (WAIT + 1) @(negedge clk);
    vectors++;
    if (d_ack !== 1'b1 || d_rddata !== 32'h2222_2222 || if_rddata !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL iso_load: got ack=%b d=%h i=%h, want 1/22222222/11111111", d_ack,
               d_rddata, if_rddata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-schedule model: a grant at IDLE cycle t occupies t+1..t+WAIT on the bus
  // and acks at t+WAIT+1; the next IDLE cycle follows.
  task automatic test_random();
    int unsigned streak = 0;
    bit          act = 1'b0;
    bit          done_ph, data_wins, g_own, g_wren;
    int          g_t = 0;
    logic [31:0] g_addr = '0, last_addr = '0, last_wdata = '0, e_if = '0, e_d = '0;
    mem_ovr_en = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_wren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    g_own = 1'b0; g_wren = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      done_ph = act && (t == g_t + int'(WAIT) + 1);
      if (done_ph) begin
        if (!g_own) e_if = mem_f(g_addr);
        else if (!g_wren) e_d = mem_f(g_addr);
      end
      vectors++;
      if ({busy, bus_wren, if_ack, d_ack} !==
          {act, act && (t == g_t + 1) && g_wren, done_ph && !g_own, done_ph && g_own}) begin
        miscompares++;
        $display("FAIL rand_ctl: t=%0d got busy/wren/iack/dack=%b%b%b%b, want %b%b%b%b", t,
                 busy, bus_wren, if_ack, d_ack, act, act && (t == g_t + 1) && g_wren,
                 done_ph && !g_own, done_ph && g_own);
      end
      vectors++;
      if (bus_addr !== last_addr || bus_wrdata !== last_wdata) begin
        miscompares++;
        $display("FAIL rand_bus: t=%0d got %h/%h, want %h/%h", t, bus_addr, bus_wrdata,
                 last_addr, last_wdata);
      end
      vectors++;
      if (if_rddata !== e_if || d_rddata !== e_d) begin
        miscompares++;
        $display("FAIL rand_rddata: t=%0d got %h/%h, want %h/%h", t, if_rddata, d_rddata,
                 e_if, e_d);
      end
      if (act) begin
        vectors++;
        if (owner !== g_own) begin
          miscompares++;
          $display("FAIL rand_owner: t=%0d got %b, want %b", t, owner, g_own);
        end
      end
      if (done_ph && !g_own) begin
        if_req = 1'b0;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (done_ph && g_own) begin
        d_req = 1'b0;
      end else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_addr = $urandom & 32'hFFFF_FFFC;
        d_wrdata = $urandom; d_wren = 1'($urandom_range(1));
      end
      if (done_ph) begin
        act = 1'b0;
      end else if (!act) begin
        if (if_req || d_req) begin
          data_wins = d_req && !(if_req && streak == MAXS);
          if (data_wins && if_req) streak = (streak < MAXS) ? streak + 1 : streak;
          else streak = 0;
          act        = 1'b1;
          g_t        = t;
          g_own      = data_wins;
          g_addr     = data_wins ? d_addr : if_addr;
          g_wren     = data_wins && d_wren;
          last_addr  = g_addr;
          last_wdata = data_wins ? d_wrdata : 32'h0;
        end else begin
          streak = 0;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (WAIT + 3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wrdata = '0; d_wren = 1'b0;
    mem_ovr_en = 1'b0; mem_ovr = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_isolation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
